// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared hazard-unit vocabulary: forwarding codes, Tuse/Tnew classes and the per-stage producer record.
// The decoder builds its Tuse/Tnew fields from these same enums.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_sel_e;

    typedef enum logic [1:0] {
        TUSE_BR   = 2'd0,
        TUSE_ALU  = 2'd1,
        TUSE_ST   = 2'd2,
        TUSE_NONE = 2'd3
    } tuse_e;

    typedef enum logic [1:0] {
        TNEW_JAL  = 2'd0,
        TNEW_ALU  = 2'd1,
        TNEW_LOAD = 2'd2
    } tnew_e;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        logic       valid;
        logic       we;
        reg_idx_t   dst;
        reg_idx_t   rs;
        reg_idx_t   rt;
        logic [1:0] tnew;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '0;

    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // $0 is hard-wired zero, so it can never be a forwarding or stall source.
    function automatic logic hits(input stage_t s, input reg_idx_t r);
        return s.valid & s.we & (s.dst == r) & (r != 5'd0);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// D-stage decode word into the hazard unit and its stall/forward controls back to the datapath.
// Purely combinational signal bundle; no handshake, the datapath obeys stall every cycle.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipe_hazard_ctrl_pkg::*;

    logic             d_valid;
    reg_idx_t         d_rs;
    reg_idx_t         d_rt;
    logic [1:0]       d_tuse_rs;
    logic [1:0]       d_tuse_rt;
    logic             d_we;
    reg_idx_t         d_dst;
    logic [1:0]       d_tnew;
    logic             stall;
    logic [1:0]       fwd_d_rs;
    logic [1:0]       fwd_d_rt;
    logic [1:0]       fwd_e_rs;
    logic [1:0]       fwd_e_rt;
    logic [1:0]       fwd_m_rt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_we, d_dst, d_tnew,
        input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, stall_cnt
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_we, d_dst, d_tnew,
        output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, stall_cnt
    );

endinterface

// File: rtl/hazard_stage_reg.sv
// One pipeline-stage producer record; loads every clock, i_bubble loads an empty record instead.
// Latency one cycle; no backpressure, the stage always advances.
module hazard_stage_reg
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_bubble,
    input  stage_t i_dat,
    output stage_t o_dat
);

    stage_t r_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dat <= STAGE_BUBBLE;
        end else if (i_bubble) begin
            r_dat <= STAGE_BUBBLE;
        end else begin
            r_dat <= i_dat;
        end
    end

    assign o_dat = r_dat;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard unit for the 5-stage pipe: tracks E/M/W producers, raises stall on Tuse<Tnew, picks forward sources.
// stall/fwd are combinational from D inputs and stage state; stall freezes F/D and bubbles D/E.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave hz
);

    stage_t           w_d_rec;
    stage_t           w_e;
    stage_t           w_m;
    stage_t           w_w;
    stage_t           w_m_in;
    stage_t           w_w_in;
    logic             w_stall;
    logic             w_e_bubble;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_unused_ok;

    function automatic logic needs_stall(input stage_t e, input stage_t m,
                                         input reg_idx_t r, input logic [1:0] tuse);
        return (tuse != TUSE_NONE) &&
               ((hits(e, r) && (tuse < e.tnew)) || (hits(m, r) && (tuse < m.tnew)));
    endfunction

    // Nearest producer owns the register; if its value is not ready yet the
    // stall already covers it, so an older stage must not be selected.
    function automatic fwd_sel_e fwd_d_sel(input stage_t e, input stage_t m,
                                           input stage_t w, input reg_idx_t r);
        fwd_sel_e sel;
        sel = FWD_RF;
        if (hits(e, r)) begin
            if (e.tnew == 2'd0) sel = FWD_E;
        end else if (hits(m, r)) begin
            if (m.tnew == 2'd0) sel = FWD_M;
        end else if (hits(w, r)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

    function automatic fwd_sel_e fwd_e_sel(input stage_t m, input stage_t w, input reg_idx_t r);
        fwd_sel_e sel;
        sel = FWD_RF;
        if (hits(m, r) && (m.tnew == 2'd0)) begin
            sel = FWD_M;
        end else if (hits(w, r)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

    always_comb begin
        w_d_rec       = STAGE_BUBBLE;
        w_d_rec.valid = hz.d_valid;
        w_d_rec.we    = hz.d_valid & hz.d_we & (hz.d_dst != 5'd0);
        w_d_rec.dst   = hz.d_dst;
        w_d_rec.rs    = hz.d_rs;
        w_d_rec.rt    = hz.d_rt;
        w_d_rec.tnew  = hz.d_tnew;
    end

    always_comb begin
        w_m_in      = w_e;
        w_m_in.tnew = sat_dec(w_e.tnew);
        w_w_in      = w_m;
        w_w_in.tnew = 2'd0;
    end

    assign w_stall = hz.d_valid &&
                     (needs_stall(w_e, w_m, hz.d_rs, hz.d_tuse_rs) ||
                      needs_stall(w_e, w_m, hz.d_rt, hz.d_tuse_rt));

    assign w_e_bubble = w_stall | ~hz.d_valid;

    hazard_stage_reg u_stage_e (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_bubble (w_e_bubble),
        .i_dat    (w_d_rec),
        .o_dat    (w_e)
    );

    hazard_stage_reg u_stage_m (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_bubble (1'b0),
        .i_dat    (w_m_in),
        .o_dat    (w_m)
    );

    hazard_stage_reg u_stage_w (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_bubble (1'b0),
        .i_dat    (w_w_in),
        .o_dat    (w_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign hz.stall     = w_stall;
    assign hz.fwd_d_rs  = hz.d_valid ? fwd_d_sel(w_e, w_m, w_w, hz.d_rs) : FWD_RF;
    assign hz.fwd_d_rt  = hz.d_valid ? fwd_d_sel(w_e, w_m, w_w, hz.d_rt) : FWD_RF;
    assign hz.fwd_e_rs  = fwd_e_sel(w_m, w_w, w_e.rs);
    assign hz.fwd_e_rt  = fwd_e_sel(w_m, w_w, w_e.rt);
    assign hz.fwd_m_rt  = hits(w_w, w_m.rt) ? FWD_W : FWD_RF;
    assign hz.stall_cnt = r_stall_cnt;

    // Store data only reads rt, and W results are final, so these fields have no consumer.
    assign w_unused_ok = ^{w_m.rs, w_w.rs, w_w.rt, w_w.tnew};

endmodule
